// File: rtl/pkt_hdr_parser_pkg.sv
// Shared types and constants for the IPv4 header parser.
//   pk_head_info_t : 96-bit flow record {s_ip, d_ip, s_port, d_port}
//   parser_state_t : parser FSM state encoding
//   has_ports()    : true for protocols whose first L4 word carries ports
package pkt_hdr_parser_pkg;

    localparam logic [3:0] IPV4_VER  = 4'd4;
    localparam logic [3:0] IHL_MIN   = 4'd5;
    localparam logic [7:0] PROTO_TCP = 8'd6;
    localparam logic [7:0] PROTO_UDP = 8'd17;

    typedef struct packed {
        logic [31:0] s_ip;
        logic [31:0] d_ip;
        logic [15:0] s_port;
        logic [15:0] d_port;
    } pk_head_info_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_OPT,
        ST_L4,
        ST_DRAIN
    } parser_state_t;

    function automatic logic has_ports(input logic [7:0] proto);
        return (proto == PROTO_TCP) || (proto == PROTO_UDP);
    endfunction

endpackage

// File: rtl/pkt_hdr_parser_if.sv
// Stream-in / record-out bundle of the header parser.
//   s_valid/s_ready/s_data/s_sop/s_eop : 32-bit big-endian IPv4 word stream
//   out_en/out_ready/out_pkt_info      : record push towards the flow prioritiser
// slave = parser side, master = source / prioritiser side.
interface pkt_hdr_parser_if #(
    parameter int DWIDTH = 32
);
    import pkt_hdr_parser_pkg::*;

    logic              s_valid;
    logic              s_ready;
    logic [DWIDTH-1:0] s_data;
    logic              s_sop;
    logic              s_eop;
    logic              out_en;
    logic              out_ready;
    pk_head_info_t     out_pkt_info;

    modport slave (
        input  s_valid, s_data, s_sop, s_eop, out_ready,
        output s_ready, out_en, out_pkt_info
    );

    modport master (
        output s_valid, s_data, s_sop, s_eop, out_ready,
        input  s_ready, out_en, out_pkt_info
    );

endinterface

// File: rtl/pkt_hdr_parser.sv
// IPv4 header parser: extracts {sIP, dIP, sPort, dPort} from a word stream and
// pushes one record per good packet; malformed or truncated packets are dropped
// and counted.
//   clk      : clock, all logic on posedge
//   rst      : asynchronous active-low reset
//   bus      : stream input and record output (pkt_hdr_parser_if.slave)
//   pkt_cnt  : records emitted, saturating
//   drop_cnt : packets dropped, saturating
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for a word with s_sop
// ST_HDR   | header words 1..4 (proto, sIP, dIP)
// ST_OPT   | skipping IHL-5 option words
// ST_L4    | first L4 word, ports captured here (TCP/UDP only)
// ST_DRAIN | record loaded or packet dropped, consume until s_eop
module pkt_hdr_parser
    import pkt_hdr_parser_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    pkt_hdr_parser_if.slave  bus,
    output logic [CNT_W-1:0] pkt_cnt,
    output logic [CNT_W-1:0] drop_cnt
);

    if (DWIDTH != 32) begin : g_bad_width
        $error("pkt_hdr_parser: only DWIDTH=32 is supported");
    end

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    parser_state_t state, state_nxt;
    logic [2:0]    wcnt, wcnt_nxt;
    logic [3:0]    ihl, ihl_nxt;
    logic [3:0]    opt_cnt, opt_nxt;
    logic [7:0]    proto, proto_nxt;
    logic [31:0]   s_ip, s_ip_nxt;
    logic [31:0]   d_ip, d_ip_nxt;

    logic          accept;
    logic          load_need;
    logic          reach_l4;
    logic          drop_abort;
    logic          drop_hdr;
    logic          out_pend;
    pk_head_info_t out_info;
    pk_head_info_t rec;
    logic [1:0]    drop_inc;
    logic [CNT_W:0] drop_sum;

    // load_need never looks at s_valid so that s_ready stays free of it
    always_comb begin
        state_nxt  = state;
        wcnt_nxt   = wcnt;
        ihl_nxt    = ihl;
        opt_nxt    = opt_cnt;
        proto_nxt  = proto;
        s_ip_nxt   = s_ip;
        d_ip_nxt   = d_ip;
        load_need  = 1'b0;
        reach_l4   = 1'b0;
        drop_abort = 1'b0;
        drop_hdr   = 1'b0;
        if (bus.s_sop) begin
            // a new packet pre-empts whatever was in flight; after a loaded
            // record or an earlier drop (ST_DRAIN) nothing extra is counted
            drop_abort = (state == ST_HDR) || (state == ST_OPT) || (state == ST_L4);
            if ((bus.s_data[31:28] != IPV4_VER) || (bus.s_data[27:24] < IHL_MIN)) begin
                drop_hdr  = 1'b1;
                state_nxt = bus.s_eop ? ST_IDLE : ST_DRAIN;
            end else if (bus.s_eop) begin
                drop_hdr  = 1'b1;
                state_nxt = ST_IDLE;
            end else begin
                state_nxt = ST_HDR;
                wcnt_nxt  = 3'd1;
                ihl_nxt   = bus.s_data[27:24];
            end
        end else begin
            case (state)
                ST_IDLE: ;
                ST_HDR: begin
                    wcnt_nxt = wcnt + 3'd1;
                    case (wcnt)
                        3'd2:    proto_nxt = bus.s_data[23:16];
                        3'd3:    s_ip_nxt  = bus.s_data;
                        3'd4:    d_ip_nxt  = bus.s_data;
                        default: ;
                    endcase
                    if (wcnt == 3'd4) begin
                        if (ihl == IHL_MIN) begin
                            reach_l4 = 1'b1;
                        end else begin
                            state_nxt = ST_OPT;
                            opt_nxt   = ihl - IHL_MIN;
                        end
                    end
                end
                ST_OPT: begin
                    opt_nxt = opt_cnt - 4'd1;
                    if (opt_cnt == 4'd1) reach_l4 = 1'b1;
                end
                ST_L4: begin
                    load_need = 1'b1;
                    state_nxt = bus.s_eop ? ST_IDLE : ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (bus.s_eop) state_nxt = ST_IDLE;
                end
                default: state_nxt = ST_IDLE;
            endcase
            if ((state == ST_HDR) || (state == ST_OPT)) begin
                // portless protocols load on the last header word, so the
                // following word is never consumed as an L4 word
                if (reach_l4 && !has_ports(proto)) begin
                    load_need = 1'b1;
                    state_nxt = bus.s_eop ? ST_IDLE : ST_DRAIN;
                end else if (bus.s_eop) begin
                    drop_hdr  = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (reach_l4) begin
                    state_nxt = ST_L4;
                end
            end
        end
    end

    always_comb begin
        rec      = '0;
        rec.s_ip = s_ip_nxt;
        rec.d_ip = d_ip_nxt;
        if (state == ST_L4) begin
            rec.s_port = bus.s_data[31:16];
            rec.d_port = bus.s_data[15:0];
        end
    end

    // stall only when a record must load into an occupied slot that is not
    // being pushed this cycle
    assign bus.s_ready      = !(load_need && out_pend && !bus.out_ready);
    assign bus.out_en       = out_pend && bus.out_ready;
    assign bus.out_pkt_info = out_info;
    assign accept           = bus.s_valid && bus.s_ready;

    assign drop_inc = accept ? ({1'b0, drop_abort} + {1'b0, drop_hdr}) : 2'd0;
    assign drop_sum = {1'b0, drop_cnt} + {{(CNT_W-1){1'b0}}, drop_inc};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            wcnt    <= 3'd0;
            ihl     <= 4'd0;
            opt_cnt <= 4'd0;
            proto   <= 8'd0;
            s_ip    <= 32'd0;
            d_ip    <= 32'd0;
        end else if (accept) begin
            state   <= state_nxt;
            wcnt    <= wcnt_nxt;
            ihl     <= ihl_nxt;
            opt_cnt <= opt_nxt;
            proto   <= proto_nxt;
            s_ip    <= s_ip_nxt;
            d_ip    <= d_ip_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_pend <= 1'b0;
            out_info <= '0;
        end else if (accept && load_need) begin
            out_pend <= 1'b1;
            out_info <= rec;
        end else if (bus.out_en) begin
            out_pend <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pkt_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            if (bus.out_en && (pkt_cnt != CNT_MAX)) pkt_cnt <= pkt_cnt + CNT_ONE;
            drop_cnt <= drop_sum[CNT_W] ? CNT_MAX : drop_sum[CNT_W-1:0];
        end
    end

endmodule

// File: tb/tb_pkt_hdr_parser.sv
module tb_pkt_hdr_parser;
    import pkt_hdr_parser_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] pkt_cnt;
    logic [15:0] drop_cnt;
    int          checks = 0;
    int          errors = 0;

    pkt_hdr_parser_if #(.DWIDTH(32)) bus ();

    pkt_hdr_parser #(.DWIDTH(32), .CNT_W(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .pkt_cnt  (pkt_cnt),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    logic [95:0] got_q[$];
    logic        saw_stall = 1'b0;
    logic [31:0] pkt_q[$];

    always @(negedge clk) begin
        if (rst && bus.out_en === 1'b1) got_q.push_back(bus.out_pkt_info);
        if (rst && bus.s_ready !== 1'b1) saw_stall = 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] d, input logic sop, input logic eop);
        int n;
        n = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_sop   = sop;
        bus.s_eop   = eop;
        @(negedge clk);
        while (bus.s_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
        bus.s_sop   = 1'b0;
        bus.s_eop   = 1'b0;
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL send_word_timeout s_ready stuck low for word %h", d);
        end
    endtask

    task automatic build_pkt(input logic [3:0] ver, input logic [3:0] ihl, input logic [7:0] proto,
                             input logic [31:0] sip, input logic [31:0] dip, input logic [31:0] l4,
                             input int npay);
        pkt_q.delete();
        pkt_q.push_back({ver, ihl, 8'h00, 16'h0040});
        pkt_q.push_back(32'h1C46_4000);
        pkt_q.push_back({8'h40, proto, 16'h0000});
        pkt_q.push_back(sip);
        pkt_q.push_back(dip);
        for (int i = 0; i < int'(ihl) - 5; i++) pkt_q.push_back(32'h0101_0100 + i);
        pkt_q.push_back(l4);
        for (int i = 0; i < npay; i++) pkt_q.push_back(32'hC0DE_0000 + i);
    endtask

    task automatic send_pkt(input int last);
        int l;
        l = (last < 0) ? pkt_q.size() - 1 : last;
        for (int i = 0; i <= l; i++) send_word(pkt_q[i], i == 0, i == l);
    endtask

    task automatic test_reset();
        bus.s_valid   = 1'b0;
        bus.s_data    = 32'h0;
        bus.s_sop     = 1'b0;
        bus.s_eop     = 1'b0;
        bus.out_ready = 1'b1;
        rst = 1'b0;
        repeat (3) step();
        checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready got %b exp 1", bus.s_ready); end
        checks++; if (bus.out_en !== 1'b0) begin errors++; $display("FAIL reset_out_en got %b exp 0", bus.out_en); end
        checks++; if (bus.out_pkt_info !== 96'h0) begin errors++; $display("FAIL reset_info got %h exp 0", bus.out_pkt_info); end
        checks++; if (pkt_cnt !== 16'd0) begin errors++; $display("FAIL reset_pkt_cnt got %0d exp 0", pkt_cnt); end
        checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL reset_drop_cnt got %0d exp 0", drop_cnt); end
        rst = 1'b1;
        step();
    endtask

    task automatic test_tcp();
        logic [95:0] exp;
        exp = 96'h0A000001_0A000002_1234_0050;
        build_pkt(4'd4, 4'd5, 8'd6, 32'h0A000001, 32'h0A000002, 32'h1234_0050, 2);
        for (int i = 0; i <= 5; i++) send_word(pkt_q[i], i == 0, 1'b0);
        checks++; if (bus.out_en !== 1'b1) begin errors++; $display("FAIL tcp_latency out_en got %b exp 1", bus.out_en); end
        checks++; if (bus.out_pkt_info !== exp) begin errors++; $display("FAIL tcp_info_live got %h exp %h", bus.out_pkt_info, exp); end
        send_word(pkt_q[6], 1'b0, 1'b0);
        send_word(pkt_q[7], 1'b0, 1'b1);
        repeat (2) step();
        checks++; if (got_q.size() != 1) begin errors++; $display("FAIL tcp_count got %0d exp 1", got_q.size()); end
        checks++; if (got_q.size() < 1 || got_q[0] !== exp) begin errors++; $display("FAIL tcp_record got %h exp %h", (got_q.size() > 0) ? got_q[0] : 96'h0, exp); end
        checks++; if (pkt_cnt !== 16'd1) begin errors++; $display("FAIL tcp_pkt_cnt got %0d exp 1", pkt_cnt); end
        checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL tcp_drop_cnt got %0d exp 0", drop_cnt); end
    endtask

    task automatic test_udp_opts();
        logic [95:0] exp;
        exp = 96'hC0A80101_C0A80102_0035_C000;
        build_pkt(4'd4, 4'd7, 8'd17, 32'hC0A80101, 32'hC0A80102, 32'h0035_C000, 1);
        send_pkt(-1);
        repeat (3) step();
        checks++; if (got_q.size() != 2) begin errors++; $display("FAIL udp_count got %0d exp 2", got_q.size()); end
        checks++; if (got_q.size() < 2 || got_q[1] !== exp) begin errors++; $display("FAIL udp_record got %h exp %h", (got_q.size() > 1) ? got_q[1] : 96'h0, exp); end
        checks++; if (pkt_cnt !== 16'd2) begin errors++; $display("FAIL udp_pkt_cnt got %0d exp 2", pkt_cnt); end
    endtask

    task automatic test_icmp();
        logic [95:0] exp;
        exp = 96'hAC100001_AC100002_0000_0000;
        saw_stall = 1'b0;
        build_pkt(4'd4, 4'd5, 8'd1, 32'hAC100001, 32'hAC100002, 32'hDEAD_BEEF, 3);
        send_pkt(-1);
        repeat (3) step();
        checks++; if (got_q.size() != 3) begin errors++; $display("FAIL icmp_count got %0d exp 3", got_q.size()); end
        checks++; if (got_q.size() < 3 || got_q[2] !== exp) begin errors++; $display("FAIL icmp_record got %h exp %h", (got_q.size() > 2) ? got_q[2] : 96'h0, exp); end
        checks++; if (saw_stall !== 1'b0) begin errors++; $display("FAIL icmp_no_stall saw s_ready low got %b exp 0", saw_stall); end
        checks++; if (pkt_cnt !== 16'd3 || drop_cnt !== 16'd0) begin errors++; $display("FAIL icmp_counts got %0d/%0d exp 3/0", pkt_cnt, drop_cnt); end
    endtask

    task automatic test_drops();
        logic [95:0] exp;
        exp = 96'h01020304_05060708_AAAA_5555;
        build_pkt(4'd6, 4'd5, 8'd6, 32'h11111111, 32'h22222222, 32'h1234_5678, 1);
        send_pkt(-1);
        build_pkt(4'd4, 4'd5, 8'd6, 32'h33333333, 32'h44444444, 32'h1234_5678, 1);
        send_pkt(3);
        repeat (2) step();
        checks++; if (got_q.size() != 3) begin errors++; $display("FAIL drop_no_record got %0d exp 3", got_q.size()); end
        checks++; if (drop_cnt !== 16'd2) begin errors++; $display("FAIL drop_cnt_two got %0d exp 2", drop_cnt); end
        checks++; if (pkt_cnt !== 16'd3) begin errors++; $display("FAIL drop_pkt_cnt got %0d exp 3", pkt_cnt); end
        build_pkt(4'd4, 4'd6, 8'd6, 32'h55555555, 32'h66666666, 32'h1234_5678, 0);
        for (int i = 0; i <= 2; i++) send_word(pkt_q[i], i == 0, 1'b0);
        build_pkt(4'd4, 4'd5, 8'd17, 32'h01020304, 32'h05060708, 32'hAAAA_5555, 0);
        send_pkt(-1);
        repeat (2) step();
        checks++; if (drop_cnt !== 16'd3) begin errors++; $display("FAIL abort_drop_cnt got %0d exp 3", drop_cnt); end
        checks++; if (got_q.size() != 4 || got_q[3] !== exp) begin errors++; $display("FAIL abort_restart_record got %h exp %h", (got_q.size() > 3) ? got_q[3] : 96'h0, exp); end
    endtask

    task automatic test_back_to_back();
        logic [95:0] exp_a, exp_b;
        logic        unstable;
        exp_a = 96'h0B000001_0B000002_1111_2222;
        exp_b = 96'h0B000003_0B000004_3333_4444;
        unstable = 1'b0;
        bus.out_ready = 1'b0;
        fork
            begin
                build_pkt(4'd4, 4'd5, 8'd6, 32'h0B000001, 32'h0B000002, 32'h1111_2222, 1);
                send_pkt(-1);
                build_pkt(4'd4, 4'd5, 8'd6, 32'h0B000003, 32'h0B000004, 32'h3333_4444, 1);
                send_pkt(-1);
            end
            begin
                for (int c = 1; c <= 20; c++) begin
                    step();
                    if (c >= 8 && bus.out_pkt_info !== exp_a) unstable = 1'b1;
                end
                checks++; if (unstable !== 1'b0) begin errors++; $display("FAIL b2b_hold_stable record changed while held, now %h exp %h", bus.out_pkt_info, exp_a); end
                checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL b2b_stall s_ready got %b exp 0", bus.s_ready); end
                checks++; if (bus.out_en !== 1'b0 || got_q.size() != 4) begin errors++; $display("FAIL b2b_no_push out_en %b records %0d exp 0/4", bus.out_en, got_q.size()); end
                bus.out_ready = 1'b1;
            end
        join
        repeat (3) step();
        checks++; if (got_q.size() != 6) begin errors++; $display("FAIL b2b_count got %0d exp 6", got_q.size()); end
        checks++; if (got_q.size() < 6 || got_q[4] !== exp_a || got_q[5] !== exp_b) begin errors++; $display("FAIL b2b_order got %h,%h exp %h,%h", (got_q.size() > 4) ? got_q[4] : 96'h0, (got_q.size() > 5) ? got_q[5] : 96'h0, exp_a, exp_b); end
        checks++; if (pkt_cnt !== 16'd6) begin errors++; $display("FAIL b2b_pkt_cnt got %0d exp 6", pkt_cnt); end
    endtask

    task automatic test_reset_mid_opt();
        logic [95:0] exp_pend, exp_new;
        int          n0;
        exp_pend = 96'h0C000001_0C000002_7777_8888;
        exp_new  = 96'h0D000001_0D000002_9999_AAAA;
        bus.out_ready = 1'b0;
        build_pkt(4'd4, 4'd5, 8'd6, 32'h0C000001, 32'h0C000002, 32'h7777_8888, 0);
        send_pkt(-1);
        build_pkt(4'd4, 4'd8, 8'd6, 32'h0E000001, 32'h0E000002, 32'h5555_6666, 0);
        for (int i = 0; i <= 5; i++) send_word(pkt_q[i], i == 0, 1'b0);
        checks++; if (bus.out_pkt_info !== exp_pend) begin errors++; $display("FAIL rst_pre_pending got %h exp %h", bus.out_pkt_info, exp_pend); end
        n0 = got_q.size();
        rst = 1'b0;
        #1;
        checks++; if (bus.out_pkt_info !== 96'h0 || bus.out_en !== 1'b0) begin errors++; $display("FAIL rst_mid_outputs info %h en %b exp 0/0", bus.out_pkt_info, bus.out_en); end
        checks++; if (pkt_cnt !== 16'd0 || drop_cnt !== 16'd0) begin errors++; $display("FAIL rst_mid_counters got %0d/%0d exp 0/0", pkt_cnt, drop_cnt); end
        checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_s_ready got %b exp 1", bus.s_ready); end
        step();
        rst = 1'b1;
        bus.out_ready = 1'b1;
        step();
        build_pkt(4'd4, 4'd5, 8'd17, 32'h0D000001, 32'h0D000002, 32'h9999_AAAA, 1);
        send_pkt(-1);
        repeat (3) step();
        checks++; if (got_q.size() != n0 + 1) begin errors++; $display("FAIL rst_after_count got %0d exp %0d", got_q.size(), n0 + 1); end
        checks++; if (got_q.size() < 1 || got_q[got_q.size()-1] !== exp_new) begin errors++; $display("FAIL rst_after_record got %h exp %h", (got_q.size() > 0) ? got_q[got_q.size()-1] : 96'h0, exp_new); end
        checks++; if (pkt_cnt !== 16'd1 || drop_cnt !== 16'd0) begin errors++; $display("FAIL rst_after_counters got %0d/%0d exp 1/0", pkt_cnt, drop_cnt); end
    endtask

    initial begin
        test_reset();
        test_tcp();
        test_udp_opts();
        test_icmp();
        test_drops();
        test_back_to_back();
        test_reset_mid_opt();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
